// File: rtl/disp_mask_pkg.sv
// Shared types and constants for the grid/window mask core: modes, register
// offsets, field positions and reset defaults.
package disp_mask_pkg;

  localparam int COORD_W = 11;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_VERT   = 2'd1,
    MODE_HORZ   = 2'd2,
    MODE_GRID   = 2'd3
  } mode_e;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_GEOM  = 2'd1;
  localparam logic [1:0] REG_LIMIT = 2'd2;
  localparam logic [1:0] REG_EDGE  = 2'd3;

  localparam int CTRL_MODE_LSB = 0;
  localparam int GEOM_W_LSB    = 0;
  localparam int GEOM_H_LSB    = 16;
  localparam int LIM_X_LSB     = 0;
  localparam int LIM_Y_LSB     = 16;

  localparam int DEF_CELL_W = 90;
  localparam int DEF_CELL_H = 80;
  localparam int DEF_X_LIM  = 720;
  localparam int DEF_Y_LIM  = 400;
  localparam int DEF_MODE   = 1;

  typedef struct packed {
    mode_e               mode;
    logic [COORD_W-1:0]  cell_w;
    logic [COORD_W-1:0]  cell_h;
    logic [COORD_W-1:0]  x_lim;
    logic [COORD_W-1:0]  y_lim;
  } cfg_t;

  function automatic logic [COORD_W-1:0] min_c(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/disp_mask_axis_pos.sv
// Per-axis position-in-cell tracker; pos_next and the edge distance are
// combinational so masking has no pipeline latency.
module disp_mask_axis_pos
  import disp_mask_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] c,
  input  logic [COORD_W-1:0] n,
  output logic [COORD_W-1:0] pos_next,
  output logic [COORD_W-1:0] d
);

  logic [COORD_W-1:0] c_q;
  logic [COORD_W-1:0] pos_q;
  logic [COORD_W-1:0] last;

  assign last = n - COORD_W'(1);

  // NOTE: pos_next gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pos_next = pos_q;
    if (c == '0) begin
      pos_next = '0;
    end else if (c != c_q) begin
      pos_next = (pos_q == last) ? '0 : pos_q + COORD_W'(1);
    end
  end

  // If pos_next ever exceeds last the subtraction wraps high and min picks pos_next.
  assign d = min_c(pos_next, last - pos_next);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q   <= '0;
      pos_q <= '0;
    end else begin
      c_q   <= c;
      pos_q <= pos_next;
    end
  end

endmodule

// File: rtl/disp_grid_mask_core.sv
// Video mask core: shaded grid edges over the pixel stream plus active-window
// blanking, with slot-bus settings double-buffered to frame start.
module disp_grid_mask_core
  import disp_mask_pkg::COORD_W, disp_mask_pkg::mode_e, disp_mask_pkg::cfg_t,
         disp_mask_pkg::min_c, disp_mask_pkg::MODE_BYPASS, disp_mask_pkg::MODE_VERT,
         disp_mask_pkg::MODE_HORZ, disp_mask_pkg::MODE_GRID, disp_mask_pkg::REG_CTRL,
         disp_mask_pkg::REG_GEOM, disp_mask_pkg::REG_LIMIT, disp_mask_pkg::REG_EDGE,
         disp_mask_pkg::CTRL_MODE_LSB, disp_mask_pkg::GEOM_W_LSB, disp_mask_pkg::GEOM_H_LSB,
         disp_mask_pkg::LIM_X_LSB, disp_mask_pkg::LIM_Y_LSB;
#(
  parameter int CW         = 4,
  parameter int SHADE_W    = 4,
  parameter int DEF_CELL_W = disp_mask_pkg::DEF_CELL_W,
  parameter int DEF_CELL_H = disp_mask_pkg::DEF_CELL_H,
  parameter int DEF_X_LIM  = disp_mask_pkg::DEF_X_LIM,
  parameter int DEF_Y_LIM  = disp_mask_pkg::DEF_Y_LIM,
  parameter int DEF_MODE   = disp_mask_pkg::DEF_MODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       x,
  input  logic [10:0]       y,
  input  logic              cs,
  input  logic              write,
  input  logic [13:0]       addr,
  input  logic [31:0]       wr_data,
  input  logic [3*CW-1:0]   si_rgb,
  output logic [3*CW-1:0]   so_rgb
);

  localparam int PW = 3 * CW;

  localparam cfg_t RST_CFG = '{
    mode:   mode_e'(2'(DEF_MODE)),
    cell_w: COORD_W'(DEF_CELL_W),
    cell_h: COORD_W'(DEF_CELL_H),
    x_lim:  COORD_W'(DEF_X_LIM),
    y_lim:  COORD_W'(DEF_Y_LIM)
  };

  cfg_t               shd_cfg, shd_cfg_nxt, act_cfg;
  logic [PW-1:0]      shd_edge, shd_edge_nxt, act_edge;
  logic [COORD_W-1:0] y_prev;
  logic               wr_en, frame_start;
  logic [COORD_W-1:0] pos_x, pos_y, dx, dy, d_sel;
  int                 shift;
  logic               unused_bits;

  assign wr_en       = cs && write;
  assign frame_start = (y == '0) && (x == '0) && (y_prev != '0);
  assign unused_bits = ^{addr[13:2], wr_data, pos_x, pos_y};

  // Shadow with this cycle's write already applied, so a write coinciding
  // with frame start reaches the active set directly.
  always_comb begin
    shd_cfg_nxt  = shd_cfg;
    shd_edge_nxt = shd_edge;
    if (wr_en) begin
      case (addr[1:0])
        REG_CTRL:  shd_cfg_nxt.mode = mode_e'(wr_data[CTRL_MODE_LSB +: 2]);
        REG_GEOM: begin
          shd_cfg_nxt.cell_w = (wr_data[GEOM_W_LSB +: COORD_W] == '0) ? COORD_W'(1)
                                                                      : wr_data[GEOM_W_LSB +: COORD_W];
          shd_cfg_nxt.cell_h = (wr_data[GEOM_H_LSB +: COORD_W] == '0) ? COORD_W'(1)
                                                                      : wr_data[GEOM_H_LSB +: COORD_W];
        end
        REG_LIMIT: begin
          shd_cfg_nxt.x_lim = wr_data[LIM_X_LSB +: COORD_W];
          shd_cfg_nxt.y_lim = wr_data[LIM_Y_LSB +: COORD_W];
        end
        REG_EDGE:  shd_edge_nxt = wr_data[PW-1:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shd_cfg  <= RST_CFG;
      act_cfg  <= RST_CFG;
      shd_edge <= '1;
      act_edge <= '1;
      y_prev   <= '0;
    end else begin
      shd_cfg  <= shd_cfg_nxt;
      shd_edge <= shd_edge_nxt;
      y_prev   <= y;
      if (frame_start) begin
        act_cfg  <= shd_cfg_nxt;
        act_edge <= shd_edge_nxt;
      end
    end
  end

  disp_mask_axis_pos u_pos_x (
    .clk      (clk),
    .reset    (reset),
    .c        (x),
    .n        (act_cfg.cell_w),
    .pos_next (pos_x),
    .d        (dx)
  );

  disp_mask_axis_pos u_pos_y (
    .clk      (clk),
    .reset    (reset),
    .c        (y),
    .n        (act_cfg.cell_h),
    .pos_next (pos_y),
    .d        (dy)
  );

  always_comb begin
    case (act_cfg.mode)
      MODE_VERT: d_sel = dx;
      MODE_HORZ: d_sel = dy;
      MODE_GRID: d_sel = min_c(dx, dy);
      default:   d_sel = dx;
    endcase
  end

  // Shading dims each channel harder the closer the pixel sits to an edge.
  always_comb begin
    so_rgb = si_rgb;
    shift  = 0;
    if (reset) begin
      so_rgb = '0;
    end else if (act_cfg.mode == MODE_BYPASS) begin
      so_rgb = si_rgb;
    end else if ((x >= act_cfg.x_lim) || (y >= act_cfg.y_lim)) begin
      so_rgb = '0;
    end else if (d_sel == '0) begin
      so_rgb = act_edge;
    end else if (int'(d_sel) <= SHADE_W) begin
      shift = SHADE_W + 1 - int'(d_sel);
      for (int ch = 0; ch < 3; ch++) begin
        so_rgb[ch*CW +: CW] = (shift >= CW) ? '0 : (si_rgb[ch*CW +: CW] >> shift);
      end
    end
  end

endmodule
